// File: rtl/alu_pkg.sv
// Shared ALU op codes, opcode constants and the issue-entry record used by the EX issue stage.
// ALU_ISSUE_ILLEGAL_DET_EN adds an illegal flag to each issue entry.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] pc;
`ifdef ALU_ISSUE_ILLEGAL_DET_EN
        logic        illegal;
`endif
    } issue_entry_t;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_MAIN,
        BUF_FULL
    } buf_state_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of a raw instruction into ALU operands, op code, rd and write enable.
// ALU_ISSUE_ILLEGAL_DET_EN enables the illegal funct7 / shift-immediate detector.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [3:0]  op,
    output logic [4:0]  rd,
    output logic        wen
`ifdef ALU_ISSUE_ILLEGAL_DET_EN
    ,
    output logic        illegal
`endif
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rd     = instr[11:7];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign shamt  = {27'b0, instr[24:20]};

`ifdef ALU_ISSUE_ILLEGAL_DET_EN
    logic ill;
    assign illegal = ill;
`endif

    always_comb begin
        a   = rs1_data;
        b   = imm_i;
        op  = OP_ADD;
        wen = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_DET_EN
        ill = 1'b0;
`endif
        case (opcode)
            OPC_R: begin
                b   = rs2_data;
                wen = 1'b1;
                case (funct3)
                    3'b000: op = instr[30] ? OP_SUB : OP_ADD;
                    3'b001: op = OP_SLL;
                    3'b010: op = OP_SLT;
                    3'b011: op = OP_SLTU;
                    3'b100: op = OP_XOR;
                    3'b101: op = instr[30] ? OP_SRA : OP_SRL;
                    3'b110: op = OP_OR;
                    default: op = OP_AND;
                endcase
`ifdef ALU_ISSUE_ILLEGAL_DET_EN
                ill = (instr[31:25] != 7'b0000000 && instr[31:25] != 7'b0100000) ||
                      (instr[31:25] == 7'b0100000 && funct3 != 3'b000 && funct3 != 3'b101);
`endif
            end
            OPC_I: begin
                wen = 1'b1;
                case (funct3)
                    3'b000: op = OP_ADD;
                    3'b001: begin
                        op = OP_SLL;
                        b  = shamt;
                    end
                    3'b010: op = OP_SLT;
                    3'b011: op = OP_SLTU;
                    3'b100: op = OP_XOR;
                    3'b101: begin
                        op = instr[30] ? OP_SRA : OP_SRL;
                        b  = shamt;
                    end
                    3'b110: op = OP_OR;
                    default: op = OP_AND;
                endcase
`ifdef ALU_ISSUE_ILLEGAL_DET_EN
                ill = (funct3 == 3'b001 && instr[31:25] != 7'b0000000) ||
                      (funct3 == 3'b101 && instr[31:25] != 7'b0000000 && instr[31:25] != 7'b0100000);
`endif
            end
            OPC_LUI: begin
                a   = 32'b0;
                b   = imm_u;
                wen = 1'b1;
            end
            OPC_AUIPC: begin
                a   = pc;
                b   = imm_u;
                wen = 1'b1;
            end
            default: begin
                a = rs1_data;
            end
        endcase
`ifdef ALU_ISSUE_ILLEGAL_DET_EN
        if (ill) begin
            op  = OP_ADD;
            wen = 1'b0;
        end
`endif
        // x0 is never written, whatever the class
        if (rd == 5'd0) begin
            wen = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// EX-stage issue register: decodes ID's instruction and holds it in a main + skid buffer pair.
// ALU_ISSUE_ILLEGAL_DET_EN exposes out_illegal for malformed R-type / shift-immediate encodings.
module alu_issue
    import alu_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic [XLEN-1:0] out_pc
`ifdef ALU_ISSUE_ILLEGAL_DET_EN
    ,
    output logic            out_illegal
`endif
);

    buf_state_t   state_q;
    buf_state_t   state_d;
    issue_entry_t dec_entry;
    issue_entry_t main_q;
    issue_entry_t skid_q;
    logic         accept;
    logic         consume;
    logic         load_main;
    logic         main_from_skid;
    logic         load_skid;

    alu_issue_decode u_decode (
        .instr    (in_instr),
        .pc       (in_pc),
        .rs1_data (in_rs1_data),
        .rs2_data (in_rs2_data),
        .a        (dec_entry.a),
        .b        (dec_entry.b),
        .op       (dec_entry.op),
        .rd       (dec_entry.rd),
        .wen      (dec_entry.wen)
`ifdef ALU_ISSUE_ILLEGAL_DET_EN
        ,
        .illegal  (dec_entry.illegal)
`endif
    );

    assign dec_entry.pc = in_pc;

    assign in_ready  = (state_q != BUF_FULL);
    assign out_valid = (state_q != BUF_EMPTY);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush wins over any accept/consume in the same cycle
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_d   = BUF_MAIN;
                        load_main = 1'b1;
                    end
                end
                BUF_MAIN: begin
                    if (accept && consume) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = BUF_FULL;
                        load_skid = 1'b1;
                    end else if (consume) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (consume) begin
                        state_d        = BUF_MAIN;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q    <= '0;
            main_q.op <= OP_ADD;
            main_q.pc <= RESET_PC;
        end else if (load_main) begin
            main_q <= dec_entry;
        end else if (main_from_skid) begin
            main_q <= skid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q    <= '0;
            skid_q.op <= OP_ADD;
            skid_q.pc <= RESET_PC;
        end else if (load_skid) begin
            skid_q <= dec_entry;
        end
    end

    assign alu_a   = main_q.a;
    assign alu_b   = main_q.b;
    assign alu_op  = main_q.op;
    assign out_rd  = main_q.rd;
    assign out_wen = main_q.wen;
    assign out_pc  = main_q.pc;
`ifdef ALU_ISSUE_ILLEGAL_DET_EN
    assign out_illegal = main_q.illegal;
`endif

endmodule
